// File: rtl/pulse_count_scheduler.sv
// ---------------------------------------------------------------------------
// pulse_count_scheduler
//
// Time-shared mod-PERIOD "ones" counting detector. Up to NCH requesters
// present one serial bit each per transaction. Requesters are served
// round-robin, one at a time. Each channel keeps a private count context
// and a detect flag that is set when its count wraps to 0.
//
// Ports
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   req       : per-channel request level, held until gnt is seen
//   ain       : per-channel data bit, valid while the matching req is high
//   clear     : per-channel synchronous context clear (ctx=0, yout=1)
//   gnt       : one-hot, one-cycle grant (the channel's ain was taken)
//   busy      : high while a transaction is in EXEC or WB
//   done      : one-cycle pulse when a transaction completes
//   done_ch   : channel of the completed transaction (held until next done)
//   count_out : updated count of that channel (held until next done)
//   yout      : per-channel detect flag
// ---------------------------------------------------------------------------
module pulse_count_scheduler #(
    parameter int NCH    = 4,
    parameter int PERIOD = 3,
    parameter int CW     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           ain,
    input  logic [NCH-1:0]           clear,
    output logic [NCH-1:0]           gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NCH)-1:0]   done_ch,
    output logic [CW-1:0]            count_out,
    output logic [NCH-1:0]           yout
);

    localparam int LW = $clog2(NCH);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [CW-1:0]   ctx [NCH];
    logic [LW-1:0]   last_granted;
    logic [LW-1:0]   ch_lat;
    logic            ain_lat;
    logic [CW-1:0]   new_q;
    logic            killed;

    logic            pick_valid;
    logic [LW-1:0]   pick_idx;
    int              scan_idx;
    logic [CW-1:0]   cur_ctx;
    logic [CW-1:0]   new_val;
    logic            discard;

    // Round-robin search starting just after the last granted channel,
    // plus the three-state sequencing IDLE -> EXEC -> WB -> IDLE.
    always_comb begin
        next_state = state;
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            scan_idx = (int'(last_granted) + 1 + k) % NCH;
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx[LW-1:0];
            end
        end
        case (state)
            IDLE:    if (pick_valid) next_state = EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Detector update for the latched channel: a 1 advances the count
    // modulo PERIOD, a 0 holds it. A clear seen in EXEC or WB for the
    // in-flight channel discards the write-back.
    always_comb begin
        cur_ctx = ctx[ch_lat];
        new_val = cur_ctx;
        if (ain_lat) begin
            new_val = (cur_ctx == CW'(PERIOD - 1)) ? '0 : cur_ctx + 1'b1;
        end
        discard = killed || clear[ch_lat];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: latch the winner, compute, write back, report. The clear
    // loop sits last so a clear beats a write-back to the same channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctx[i] <= '0;
            end
            yout         <= '1;
            last_granted <= LW'(NCH - 1);
            ch_lat       <= '0;
            ain_lat      <= 1'b0;
            new_q        <= '0;
            killed       <= 1'b0;
            gnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_ch      <= '0;
            count_out    <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        ch_lat       <= pick_idx;
                        ain_lat      <= ain[pick_idx];
                        last_granted <= pick_idx;
                        gnt          <= NCH'(1) << pick_idx;
                        busy         <= 1'b1;
                    end
                end
                EXEC: begin
                    new_q  <= new_val;
                    killed <= clear[ch_lat];
                end
                WB: begin
                    done    <= 1'b1;
                    done_ch <= ch_lat;
                    busy    <= 1'b0;
                    killed  <= 1'b0;
                    if (discard) begin
                        count_out <= '0;
                    end else begin
                        count_out   <= new_q;
                        ctx[ch_lat] <= new_q;
                        if (ain_lat) begin
                            yout[ch_lat] <= (new_q == '0);
                        end
                    end
                end
                default: ;
            endcase
            for (int i = 0; i < NCH; i++) begin
                if (clear[i]) begin
                    ctx[i]  <= '0;
                    yout[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_count_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pulse_count_scheduler
//
// Directed stimulus with hand-computed expectations pushed into two
// queues (expected grants, expected completions); a monitor pops and
// compares whenever the DUT shows gnt or done.
// ---------------------------------------------------------------------------
module tb_pulse_count_scheduler;

    localparam int NCH = 4;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] req;
    logic [NCH-1:0] ain;
    logic [NCH-1:0] clear;
    logic [NCH-1:0] gnt;
    logic           busy;
    logic           done;
    logic [1:0]     done_ch;
    logic [1:0]     count_out;
    logic [NCH-1:0] yout;

    typedef struct {
        int ch;
        int cnt;
        int y;
    } exp_t;

    exp_t sbQ[$];
    int   gntQ[$];
    exp_t mon_e;
    int   mon_g;

    int total;
    int bad;
    int unsigned cyc;
    int unsigned last_gnt_cyc;

    pulse_count_scheduler #(.NCH(NCH), .PERIOD(3), .CW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ain       (ain),
        .clear     (clear),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_ch   (done_ch),
        .count_out (count_out),
        .yout      (yout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expectDone(input int ch, input int cnt, input int y);
        exp_t e;
        e.ch  = ch;
        e.cnt = cnt;
        e.y   = y;
        sbQ.push_back(e);
    endtask

    // Monitor: compares every grant and every completion against the queues.
    always @(negedge clk) begin
        if (gnt != '0) begin
            last_gnt_cyc = cyc;
            if (gntQ.size() == 0) begin
                checkOutput("unexpected_gnt", int'(gnt), 0);
            end else begin
                mon_g = gntQ.pop_front();
                checkOutput("gnt_onehot", int'(gnt), 1 << mon_g);
            end
        end
        if (done) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                mon_e = sbQ.pop_front();
                checkOutput("done_ch", int'(done_ch), mon_e.ch);
                checkOutput("count_out", int'(count_out), mon_e.cnt);
                checkOutput("yout_ch", int'(yout[done_ch]), mon_e.y);
                checkOutput("gnt_to_done", int'(cyc - last_gnt_cyc), 2);
            end
        end
    end

    // One transaction on channel c. mode: 0 plain, 1 clear in EXEC,
    // 2 clear in WB, 3 reset asserted in WB.
    task automatic applyStimulus(input int c, input logic a, input int mode,
                                 input logic [NCH-1:0] cmask);
        bit seen;
        seen = 0;
        @(negedge clk);
        req[c] = 1'b1;
        ain[c] = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt[c]) begin
                seen = 1;
                break;
            end
        end
        req[c] = 1'b0;
        ain[c] = 1'b0;
        if (!seen) begin
            checkOutput("gnt_timeout", 0, 1);
            return;
        end
        if (mode == 1) clear = cmask;
        @(negedge clk);
        clear = '0;
        if (mode == 2) clear = cmask;
        if (mode == 3) begin
            reset = 1'b0;
            #1;
            checkOutput("async_rst_gnt", int'(gnt), 0);
            checkOutput("async_rst_busy", int'(busy), 0);
            checkOutput("async_rst_done", int'(done), 0);
            checkOutput("async_rst_count", int'(count_out), 0);
            checkOutput("async_rst_done_ch", int'(done_ch), 0);
            checkOutput("async_rst_yout", int'(yout), 15);
        end
        @(negedge clk);
        clear = '0;
    endtask

    // Hold a request mask until n grants have been seen; checks that
    // grants are spaced exactly three cycles apart.
    task automatic runBurst(input logic [NCH-1:0] rmask, input logic [NCH-1:0] amask,
                            input int n);
        int got;
        int unsigned prev;
        got  = 0;
        prev = 0;
        @(negedge clk);
        req = rmask;
        ain = amask;
        for (int i = 0; i < 20 * n; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                if (got > 0) checkOutput("gnt_spacing", int'(cyc - prev), 3);
                prev = cyc;
                got++;
                if (got == n) break;
            end
        end
        req = '0;
        ain = '0;
        if (got != n) checkOutput("burst_grants", got, n);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        last_gnt_cyc = 0;
        reset = 1'b0;
        req   = '0;
        ain   = '0;
        clear = '0;

        // Reset with random inputs, then release.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req   = NCH'($urandom);
            ain   = NCH'($urandom);
            clear = NCH'($urandom);
        end
        @(negedge clk);
        req   = '0;
        ain   = '0;
        clear = '0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_yout", int'(yout), 15);
        checkOutput("rst_gnt", int'(gnt), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_count", int'(count_out), 0);
        checkOutput("rst_done_ch", int'(done_ch), 0);

        // All contexts zero after reset: ain=0 services return 0.
        for (int c = 0; c < NCH; c++) begin
            gntQ.push_back(c);
            expectDone(c, 0, 1);
            applyStimulus(c, 1'b0, 0, '0);
        end

        // Channel 1 wraps: 1, 2, 0.
        gntQ.push_back(1); expectDone(1, 1, 0); applyStimulus(1, 1'b1, 0, '0);
        gntQ.push_back(1); expectDone(1, 2, 0); applyStimulus(1, 1'b1, 0, '0);
        gntQ.push_back(1); expectDone(1, 0, 1); applyStimulus(1, 1'b1, 0, '0);

        // Channel 2 reaches 1, then holds on ain=0.
        gntQ.push_back(2); expectDone(2, 1, 0); applyStimulus(2, 1'b1, 0, '0);
        gntQ.push_back(2); expectDone(2, 1, 0); applyStimulus(2, 1'b0, 0, '0);

        // Move the pointer to channel 3 so the full-request burst starts at 0.
        gntQ.push_back(3); expectDone(3, 0, 1); applyStimulus(3, 1'b0, 0, '0);
        // ctx = {0,0,1,0}
        gntQ.push_back(0); expectDone(0, 1, 0);
        gntQ.push_back(1); expectDone(1, 1, 0);
        gntQ.push_back(2); expectDone(2, 2, 0);
        gntQ.push_back(3); expectDone(3, 1, 0);
        gntQ.push_back(0); expectDone(0, 2, 0);
        gntQ.push_back(1); expectDone(1, 2, 0);
        gntQ.push_back(2); expectDone(2, 0, 1);
        gntQ.push_back(3); expectDone(3, 2, 0);
        runBurst(4'b1111, 4'b1111, 8);
        // ctx = {2,2,0,2}

        // Pointer to 1, then req=1010 must grant 3 before 1.
        gntQ.push_back(1); expectDone(1, 2, 0); applyStimulus(1, 1'b0, 0, '0);
        gntQ.push_back(3); expectDone(3, 2, 0);
        gntQ.push_back(1); expectDone(1, 2, 0);
        runBurst(4'b1010, 4'b0000, 2);

        // Idle clear of channel 0, then bring it to 1.
        @(negedge clk);
        clear = 4'b0001;
        @(negedge clk);
        clear = '0;
        checkOutput("idle_clear_yout0", int'(yout[0]), 1);
        gntQ.push_back(0); expectDone(0, 1, 0); applyStimulus(0, 1'b1, 0, '0);

        // Clear channel 0 during its own EXEC: result discarded.
        gntQ.push_back(0); expectDone(0, 0, 1); applyStimulus(0, 1'b1, 1, 4'b0001);
        gntQ.push_back(0); expectDone(0, 0, 1); applyStimulus(0, 1'b0, 0, '0);

        // Clear channel 0 during channel 1's WB: channel 1 unaffected.
        gntQ.push_back(1); expectDone(1, 0, 1); applyStimulus(1, 1'b1, 0, '0);
        gntQ.push_back(1); expectDone(1, 1, 0); applyStimulus(1, 1'b1, 2, 4'b0001);
        gntQ.push_back(1); expectDone(1, 1, 0); applyStimulus(1, 1'b0, 0, '0);
        checkOutput("wb_clear_yout0", int'(yout[0]), 1);

        // Asynchronous reset during WB: no done, pointer restarts at 0.
        gntQ.push_back(2);
        applyStimulus(2, 1'b1, 3, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        gntQ.push_back(1); expectDone(1, 0, 1);
        gntQ.push_back(2); expectDone(2, 0, 1);
        runBurst(4'b0110, 4'b0000, 2);

        repeat (5) @(negedge clk);
        checkOutput("sb_drained", sbQ.size(), 0);
        checkOutput("gnt_drained", gntQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_count_scheduler.md
# pulse_count_scheduler

Time-shared controller for the mod-PERIOD "ones" counting detector. Up to NCH requesters each present one serial bit (`ain`) per transaction. The block arbitrates them round-robin and keeps a private count context per channel. It runs one detector update per granted transaction and reports the updated count and the per-channel `yout` detect flag. It sits between the input channels and downstream logic, replacing one detector instance per channel.

## Interface
- `NCH`, 4: number of requester channels (2..8).
- `PERIOD`, 3: count modulus; the count wraps to 0 on reaching PERIOD.
- `CW`, 2: context/count width; must satisfy 2^CW >= PERIOD.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NCH  per-channel request; level, held until `gnt` seen.
- `ain`  in  NCH  per-channel data bit, valid whenever the matching `req` is high.
- `clear`  in  NCH  synchronous per-channel context clear.
- `gnt`  out  NCH  one-hot, one-cycle grant: the channel's `ain` has been taken.
- `busy`  out  1  high while a transaction is in flight (EXEC or WB).
- `done`  out  1  one-cycle pulse: a transaction has completed.
- `done_ch`  out  clog2(NCH)  channel index of the completed transaction.
- `count_out`  out  CW  updated count of that channel.
- `yout`  out  NCH  per-channel detect flag; 1 when that channel's count last wrapped to 0.

## Operation
- FSM states:
  - IDLE: if any `req` is high, select a channel, latch its index and `ain`, and go to EXEC. Otherwise stay in IDLE.
  - EXEC: compute `new`. If the latched ain=1, `new` = (ctx==PERIOD-1) ? 0 : ctx+1. If ain=0, `new` = ctx. Go to WB.
  - WB: write `new` to ctx[ch]. If ain=1, set yout[ch] to (new==0); if ain=0, leave yout[ch] unchanged. Register `done`, `done_ch` and `count_out=new`. Go to IDLE.
- Round-robin arbitration:
  - Search starts at (last_granted+1) mod NCH and wraps.
  - `last_granted` updates on each IDLE->EXEC transition.
  - After reset the search starts at channel 0.
- `req` is sampled only in IDLE. `req`/`ain` changes at other times are ignored.
- A requester drops `req` in the cycle after `gnt`, or keeps it high to queue another transaction. A kept request competes again under round-robin.
- `clear[i]`:
  - Sets ctx[i]=0 and yout[i]=1 at the next edge.
  - Multiple channels may be cleared in the same cycle.
- `clear[i]` while channel i is in EXEC or WB:
  - The in-flight result is discarded: no ctx or yout write-back for channel i.
  - `done` still pulses, with `done_ch`=i and `count_out`=0.
- `clear[i]` has no effect on arbitration.
- Context arithmetic is modulo PERIOD. ctx values >= PERIOD are unreachable.
- Reset (asserted asynchronously, mid-transaction included) forces:
  - state IDLE, in-flight transaction abandoned;
  - all ctx=0;
  - yout all 1;
  - gnt=0, busy=0, done=0, done_ch=0, count_out=0;
  - round-robin pointer so the next search starts at channel 0.

## Timing
- Cycle T (IDLE) samples `req`. Then:
  - T+1 (EXEC): gnt[ch]=1, busy=1.
  - T+2 (WB): gnt=0, busy=1.
  - T+3: done=1, done_ch and count_out valid, yout[ch] updated, state IDLE.
- `done_ch` and `count_out` hold until the next `done`.
- Latency is 3 cycles from the sampled request to `done`.
- Throughput is one transaction per 3 cycles. In T+3 the IDLE state samples `req` again, so back-to-back transactions show `done` in T+3 and `gnt` in T+4.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- `clear` takes effect at the edge on which it is sampled high.
- `clear` and a WB write to the same channel in the same cycle: clear wins.

## Test plan
- Reset value check:
  - Stimulus: assert reset with random inputs, release.
  - Required: yout=4'b1111, gnt=0, busy=0, done=0, count_out=0, and all ctx=0 (observed via ain=0 services returning count_out=0).
- Single-channel wrap:
  - Stimulus: channel 1 issues three ain=1 transactions.
  - Required: count_out 1, 2, 0; yout[1] 0, 0, 1; each `done` exactly 3 cycles after its IDLE sample; `done_ch`=1.
- Hold case:
  - Stimulus: channel 2 issues an ain=0 transaction after count reached 1.
  - Required: count_out=1, yout[2] unchanged.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held continuously with ain=1.
  - Required: gnt order 0,1,2,3,0,...; `done` every 3 cycles.
  - Stimulus: req=4'b1010 starting with last_granted=1.
  - Required: grant 3 next, then 1.
- Clear in flight:
  - Stimulus: clear[0] during channel 0's EXEC, with channel 0 ctx=1.
  - Required: done with done_ch=0, count_out=0; ctx[0]=0; yout[0]=1.
  - Stimulus: clear[0] during channel 1's WB.
  - Required: channel 1 result is written normally.
- Asynchronous reset mid-transaction:
  - Stimulus: drop reset during WB.
  - Required: outputs return to reset values immediately with no `done`; after release the first grant goes to the lowest requesting channel.
